// File: rtl/ena_rate_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ena_pkg
// Description : Shared constants, switch-FSM state encoding and width helper
//               for the selectable enable-rate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package ena_pkg;

    localparam int unsigned DEF_CLK_HZ = 125_000_000;
    localparam int unsigned MAX_CH     = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ena_rate_sel_div_tick.sv
`default_nettype none
// ============================================================================
// Module      : ena_div_tick
// Description : Free-running modulo-DIV counter with a registered one-cycle
//               tick in the cycle after the count reaches DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module ena_div_tick
    import ena_pkg::*;
#(
    parameter int unsigned DIV   = 2,
    parameter int unsigned CNT_W = 1
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == c_last);
            if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/ena_rate_sel.sv
`default_nettype none
// ============================================================================
// Module      : ena_rate_sel
// Description : N_CH divided enable ticks with a synchronised, glitch-free
//               channel select onto a single enable output.
// Revision    : 1.0 - initial release
// ============================================================================
module ena_rate_sel
    import ena_pkg::*;
#(
    parameter int unsigned          CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned          N_CH    = 4,
    parameter int unsigned          SEL_W   = clog2(N_CH),
    parameter logic [N_CH*32-1:0]   RATE_HZ = {32'd100, 32'd50, 32'd20, 32'd1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sw,
    output logic             ena_out,
    output logic [N_CH-1:0]  tick_all,
    output logic [SEL_W-1:0] cur_sel,
    output logic             switching
);

    // Largest divide ratio sets the shared counter width.
    function automatic int unsigned f_max_div();
        int unsigned m;
        int unsigned rate;
        m = 1;
        for (int k = 0; k < N_CH; k++) begin
            rate = RATE_HZ[k*32 +: 32];
            if (rate != 0) begin
                if ((CLK_HZ / rate) > m) begin
                    m = CLK_HZ / rate;
                end
            end
        end
        return m;
    endfunction

    localparam int unsigned      c_max_div = f_max_div();
    localparam int unsigned      c_cnt_w   = (clog2(c_max_div) > 0) ? clog2(c_max_div) : 1;
    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N_CH - 1);

    logic [N_CH-1:0]  w_tick;
    logic [SEL_W-1:0] r_sw_meta;
    logic [SEL_W-1:0] r_sw_sync;
    logic [SEL_W-1:0] w_sel_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] w_cur_sel_nxt;
    logic [SEL_W-1:0] r_tgt;
    logic [SEL_W-1:0] w_tgt_nxt;
    logic             r_ena;
    logic             w_ena_nxt;
    logic             r_switching;
    logic             w_switching_nxt;

    generate
        if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_nch
            $error("ena_rate_sel: N_CH must be in 2..16");
        end

        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            localparam int unsigned c_rate = RATE_HZ[k*32 +: 32];
            if (c_rate == 0 || c_rate > CLK_HZ) begin : g_bad_rate
                $error("ena_rate_sel: RATE_HZ channel must be in 1..CLK_HZ");
            end else begin : g_div
                ena_div_tick #(
                    .DIV   (CLK_HZ / c_rate),
                    .CNT_W (c_cnt_w)
                ) u_div (
                    .clk    (clk),
                    .rst    (rst),
                    .o_tick (w_tick[k])
                );
            end
        end
    endgenerate

    // Two-flop synchroniser for the board switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    generate
        if (N_CH == 2**SEL_W) begin : g_sel_full
            assign w_sel_s = r_sw_sync;
        end else begin : g_sel_clamp
            assign w_sel_s = (r_sw_sync > c_last_ch) ? c_last_ch : r_sw_sync;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_sel   <= '0;
            r_tgt       <= '0;
            r_ena       <= 1'b0;
            r_switching <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_tgt       <= w_tgt_nxt;
            r_ena       <= w_ena_nxt;
            r_switching <= w_switching_nxt;
        end
    end

    // The old channel keeps driving the output until the target channel
    // ticks; the handover cycle emits exactly that one target tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_sel_nxt   = r_cur_sel;
        w_tgt_nxt       = r_tgt;
        w_ena_nxt       = w_tick[r_cur_sel];
        w_switching_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_s != r_cur_sel) begin
                    w_tgt_nxt       = w_sel_s;
                    w_state_nxt     = ST_PEND;
                    w_switching_nxt = 1'b1;
                end
            end
            ST_PEND: begin
                w_switching_nxt = 1'b1;
                if (w_sel_s == r_cur_sel) begin
                    w_state_nxt     = ST_IDLE;
                    w_switching_nxt = 1'b0;
                end else if (w_sel_s != r_tgt) begin
                    w_tgt_nxt = w_sel_s;
                end else if (w_tick[r_tgt]) begin
                    w_cur_sel_nxt   = r_tgt;
                    w_state_nxt     = ST_IDLE;
                    w_switching_nxt = 1'b0;
                    w_ena_nxt       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ena_out   = r_ena;
    assign tick_all  = w_tick;
    assign cur_sel   = r_cur_sel;
    assign switching = r_switching;

endmodule
`default_nettype wire

// File: tb/tb_ena_rate_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_ena_rate_sel
// Description : Directed self-checking bench for ena_rate_sel (CLK_HZ=100,
//               DIV ch0..3 = 100,2,5,10) plus a 3-channel clamp instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ena_rate_sel;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       ena_out;
    logic [3:0] tick_all;
    logic [1:0] cur_sel;
    logic       switching;

    logic [1:0] sw3;
    logic       ena3;
    logic [2:0] tick3;
    logic [1:0] cur_sel3;
    logic       switching3;

    int n_checks;
    int n_pass;
    int cyc;
    int cnt;

    ena_rate_sel #(
        .CLK_HZ  (100),
        .N_CH    (4),
        .RATE_HZ ({32'd10, 32'd20, 32'd50, 32'd1})
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .ena_out   (ena_out),
        .tick_all  (tick_all),
        .cur_sel   (cur_sel),
        .switching (switching)
    );

    ena_rate_sel #(
        .CLK_HZ  (100),
        .N_CH    (3),
        .RATE_HZ ({32'd20, 32'd50, 32'd1})
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw3),
        .ena_out   (ena3),
        .tick_all  (tick3),
        .cur_sel   (cur_sel3),
        .switching (switching3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_ticks(input int c);
        exp_ticks = {(c % 10) == 0, (c % 5) == 0, (c % 2) == 0, (c % 100) == 0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        sw       = 2'd0;
        sw3      = 2'd3;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_ena", 32'(ena_out), 32'd0);
        check("rst_ticks", 32'(tick_all), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_switching", 32'(switching), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // 1: channel 0 and raw tick cadence
        step(1);
        check("t1_ticks_c1", 32'(tick_all), 32'(exp_ticks(1)));
        step(1);
        check("t1_ticks_c2", 32'(tick_all), 32'(exp_ticks(2)));
        step(8);
        check("t1_ticks_c10", 32'(tick_all), 32'(exp_ticks(10)));
        cnt = 0;
        while (!ena_out && cnt < 150) begin
            step(1);
            cnt++;
        end
        check("t1_first_ena_cycle", 32'(cyc), 32'd101);
        check("t1_ticks_c101", 32'(tick_all), 32'(exp_ticks(101)));
        step(1);
        check("t1_ena_c102", 32'(ena_out), 32'd0);

        // 2: switch 0 -> 2
        sw = 2'd2;
        step(2);
        check("t2_sw_c104", 32'(switching), 32'd0);
        step(1);
        check("t2_sw_c105", 32'(switching), 32'd1);
        check("t2_cur_c105", 32'(cur_sel), 32'd0);
        step(1);
        check("t2_cur_c106", 32'(cur_sel), 32'd2);
        check("t2_ena_c106", 32'(ena_out), 32'd1);
        check("t2_sw_c106", 32'(switching), 32'd0);
        step(4);
        check("t2_ena_c110", 32'(ena_out), 32'd0);
        step(1);
        check("t2_ena_c111", 32'(ena_out), 32'd1);

        // 3: 2 -> 3 -> 2 cancels without extra pulse
        sw = 2'd3;
        step(2);
        sw = 2'd2;
        step(1);
        check("t3_sw_c114", 32'(switching), 32'd1);
        step(2);
        check("t3_sw_c116", 32'(switching), 32'd0);
        check("t3_ena_c116", 32'(ena_out), 32'd1);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (ena_out) cnt++;
        end
        check("t3_pulses_117_125", 32'(cnt), 32'd1);
        check("t3_cur_c125", 32'(cur_sel), 32'd2);

        // 4: 1 -> 3 handover on a coincident tick
        sw = 2'd1;
        step(4);
        check("t4_cur_c129", 32'(cur_sel), 32'd1);
        check("t4_ena_c129", 32'(ena_out), 32'd1);
        step(3);
        sw = 2'd3;
        step(7);
        check("t4_ena_c139", 32'(ena_out), 32'd1);
        step(1);
        check("t4_sw_c140", 32'(switching), 32'd1);
        check("t4_cur_c140", 32'(cur_sel), 32'd1);
        step(1);
        check("t4_ena_c141", 32'(ena_out), 32'd1);
        check("t4_cur_c141", 32'(cur_sel), 32'd3);
        cnt = 0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            if (ena_out) cnt++;
        end
        check("t4_pulses_142_160", 32'(cnt), 32'd1);

        // 5: reset while a switch is pending
        sw = 2'd0;
        step(3);
        check("t5_sw_c163", 32'(switching), 32'd1);
        step(2);
        check("t5_ticks_c165", 32'(tick_all), 32'(exp_ticks(165)));
        rst = 1'b1;
        #1;
        check("t5_async_ena", 32'(ena_out), 32'd0);
        check("t5_async_ticks", 32'(tick_all), 32'd0);
        check("t5_async_cur", 32'(cur_sel), 32'd0);
        check("t5_async_sw", 32'(switching), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // 6: 3-channel instance clamps sw=3 to channel 2
        step(2);
        check("t6_ticks_c2", 32'(tick_all), 32'(exp_ticks(2)));
        check("t6_sw3_c2", 32'(switching3), 32'd0);
        step(1);
        check("t6_sw3_c3", 32'(switching3), 32'd1);
        step(3);
        check("t6_cur3_c6", 32'(cur_sel3), 32'd2);
        check("t6_ena3_c6", 32'(ena3), 32'd1);
        step(4);
        check("t6_ticks3_c10", 32'(tick3), 32'b110);
        step(1);
        check("t6_ena3_c11", 32'(ena3), 32'd1);
        step(1);
        check("t6_ena3_c12", 32'(ena3), 32'd0);

        // Restart on channel 0 after the mid-switch reset
        cnt = 0;
        while (!ena_out && cnt < 150) begin
            step(1);
            cnt++;
        end
        check("t5_restart_ena_cycle", 32'(cyc), 32'd101);
        check("t5_restart_cur", 32'(cur_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
